alu_display_seq: RTL
====================

# alu_display_seq

Parametrised successor of the 4-bit ALU display datapath. Latches two WIDTH-bit operands on a load strobe and computes one of eight operations into a registered result with N/Z/C/V flags. The result goes to a DIGITS-wide multiplexed seven-segment display in hex or decimal. Decimal conversion is a sequential double-dabble, so the display never shows a partial value. Sits directly under the board top; the top maps switches, buttons and the segment/anode pins.

## Interface
- WIDTH, 8, operand/result width (4..16)
- DIGITS, 8, number of display digits; must be ≥ dec_digits(WIDTH), else elaboration error
- REFRESH_DIV, 100_000, clk cycles per digit slot (1 kHz digit rate at 100 MHz)
- clk  in  1  system clock, one clock domain
- reset_n  in  1  asynchronous, active-low reset
- A, B  in  WIDTH  operands, sampled only on accepted load
- OpCode  in  3  operation, sampled on accepted load
- mode  in  1  0 = hex, 1 = decimal; sampled on accepted load
- load  in  1  level; accepted on any edge where state is IDLE
- busy  out  1  high from the edge after acceptance until the display buffer updates
- flags  out  4  {N,Z,C,V} of the last result
- Segments  out  7  {CG..CA}, active low
- Anodes  out  DIGITS  active low, at most one low

## Operation
- OpCodes:
  - 000 ADD, 001 SUB (A−B)
  - 010 AND, 011 OR, 100 XOR
  - 101 SLL by 1, 110 SRL by 1, 111 PASS A
- Result is WIDTH bits, modulo 2^WIDTH. It is always displayed unsigned.
- N = result[WIDTH−1]; Z = (result == 0).
- C rules:
  - ADD: carry out.
  - SUB: borrow, i.e. A < B unsigned.
  - SLL: bit shifted out is A[WIDTH−1]. SRL: bit shifted out is A[0].
  - All other operations: 0.
- V = signed overflow for ADD/SUB, else 0.
- FSM states IDLE → CALC → (CONV if mode = 1) → UPDATE → IDLE:
  - IDLE + load: latch A, B, OpCode, mode.
  - CALC: register the result and flags.
  - CONV: WIDTH double-dabble shift/add-3 cycles.
  - UPDATE: write the digit buffer.
- load while not IDLE is ignored; no queueing.
- Digit buffer content:
  - Hex mode: hex_digits = ceil(WIDTH/4) nibbles, leading zeros shown.
  - Decimal mode: dec_digits(WIDTH) BCD digits, leading zeros shown.
  - All slots above the active count are blank: anode held high during that slot.
- Scanner:
  - Refresh counter runs 0..REFRESH_DIV−1. On wrap, the digit index increments modulo DIGITS.
  - Anodes = ~(1 << index) for active slots.
  - Segments come from the package hex-to-7seg encoding (active low). Codes A–F are reachable only in hex mode.
- Reset (asynchronous, any state, including mid-CONV):
  - FSM to IDLE, busy = 0, flags = 0.
  - Digit buffer = 0, active count = hex_digits, index = 0, refresh counter = 0.
  - Anodes = all 1, Segments = 7'h7F.

## Timing
- Scanner outputs are registered. The first scan output appears on the first edge after reset release: digit 0 shows "0".
- Acceptance edge is e0. busy = 1 after e0.
- result and flags are valid after e1.
- Hex mode: buffer is updated and busy = 0 after e2.
- Decimal mode: buffer is updated and busy = 0 after e(2+WIDTH).
- flags update at e1; the display changes only at UPDATE.
- The next load is accepted on the edge at which busy falls is not allowed. The earliest acceptance is the following edge, because the FSM is in IDLE only after UPDATE.
- Each digit slot lasts exactly REFRESH_DIV cycles. Buffer updates take effect at the next slot boundary without resetting the scan.

## Structure
- Package alu_display_pkg holds:
  - opcode_t enum and state_t enum.
  - Function seg7_hex(logic [3:0]) returning 7 bits, active low.
  - Functions hex_digits(int) and dec_digits(int) for the number of decimal digits of 2^WIDTH−1.
- Sub-module bin_to_bcd_seq(WIDTH) implements the sequential double dabble.
  - Ports: start, bin, bcd, done.
  - Instantiated once, driven by the CONV state.

## Test plan
Bench parameters: WIDTH = 8, DIGITS = 4, REFRESH_DIV = 4.

1. Reset: hold reset_n low mid-scan → Anodes = 4'hF, Segments = 7'h7F, busy = 0, flags = 0. After release, digit 0 shows "0" (Segments = 7'h40), digit 1 shows "0", digits 2–3 blank.
2. Hex ADD: A = F0, B = 25, mode = 0 → result 15, flags N0 Z0 C1 V0. busy high for exactly 2 cycles. Digits show "1","5"; slots 2–3 have AN high.
3. Decimal SUB: A = 100, B = 45, mode = 1 → 55. busy high for 10 cycles. Digits 2..0 show "0","5","5"; slot 3 blank.
4. SUB overflow: A = 80, B = 01 → result 7F, N0 Z0 C0 V1. SUB with A = B = 3C → Z1. SRL with A = 01 → result 00, C1, Z1.
5. Scan: observe 16 cycles → Anodes sequence 1110, 1101, then 1111, 1111 for the blank hex slots, each slot 4 cycles long.
6. Robustness:
   - load pulsed during CONV → ignored; the buffer reflects only the first operation.
   - reset_n asserted at cycle 5 of CONV → IDLE, buffer 0, no stale digits shown after release.

Source files
------------

// File: rtl/alu_display_pkg.sv
// Shared types and helpers for the ALU display datapath: opcodes, FSM states,
// seven-segment encoding and digit-count helpers.
package alu_display_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_SRL  = 3'b110,
        OP_PASS = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_CONV   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg7_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'ha: s = 7'h08;
            4'hb: s = 7'h03;
            4'hc: s = 7'h46;
            4'hd: s = 7'h21;
            4'he: s = 7'h06;
            default: s = 7'h0e;
        endcase
        return s;
    endfunction

    function automatic int hex_digits(input int w);
        return (w + 3) / 4;
    endfunction

    // Number of decimal digits needed for the largest w-bit unsigned value.
    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per cycle, WIDTH steps total.
// start is a level; the first step uses bin directly, later steps use the shifter.
module bin_to_bcd_seq
    import alu_display_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = dec_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*NDIG-1:0]   bcd,
    output logic                done
);

    localparam int BCD_W = 4 * NDIG;
    localparam int SW    = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [SW-1:0]    steps_left;
    logic             active;

    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] cur,
                                                     input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = cur;
        for (int i = 0; i < NDIG; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // done marks the edge on which the final step is taken.
    assign done = active && (steps_left == SW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr         <= '0;
            bcd        <= '0;
            steps_left <= '0;
            active     <= 1'b0;
        end else if (start && !active) begin
            sr         <= {bin[WIDTH-2:0], 1'b0};
            bcd        <= {{(BCD_W-1){1'b0}}, bin[WIDTH-1]};
            steps_left <= SW'(WIDTH - 1);
            active     <= 1'b1;
        end else if (active) begin
            sr         <= {sr[WIDTH-2:0], 1'b0};
            bcd        <= dabble_step(bcd, sr[WIDTH-1]);
            steps_left <= steps_left - SW'(1);
            if (steps_left == SW'(1)) active <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_display_seq.sv
// Operand-latching ALU with N/Z/C/V flags driving a multiplexed seven-segment
// display in hex or decimal; the digit buffer only changes once a result is complete.
module alu_display_seq
    import alu_display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [2:0]        OpCode,
    input  logic              mode,
    input  logic              load,
    output logic              busy,
    output logic [3:0]        flags,
    output logic [6:0]        Segments,
    output logic [DIGITS-1:0] Anodes,
    output logic [1:0]        dbg_state
);

    localparam int HEX_D = hex_digits(WIDTH);
    localparam int DEC_D = dec_digits(WIDTH);
    localparam int BCD_W = 4 * DEC_D;
    localparam int BUF_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (DIGITS < DEC_D) begin : g_digits_check
        $error("DIGITS is too small to show a WIDTH-bit result in decimal");
    end

    // Handshake: load is a level request, taken on any edge where the FSM is IDLE.
    // busy is high from that edge until the digit-buffer write; the edge on which
    // busy falls cannot accept, the next one can. Requests while busy are dropped.
    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, result_q, alu_res;
    opcode_t          op_q;
    logic             mode_q, alu_c, alu_v, conv_done;
    logic [WIDTH:0]   ext;
    logic [BCD_W-1:0] bcd;
    logic [BUF_W-1:0] digit_buf;
    logic [CNT_W-1:0] active_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] scan_idx;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (load) state_next = ST_CALC;
            ST_CALC:   state_next = mode_q ? ST_CONV : ST_UPDATE;
            ST_CONV:   if (conv_done) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        ext     = '0;
        case (op_q)
            OP_ADD: begin
                ext     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra bit of the widened difference is the unsigned borrow.
                ext     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SRL: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: alu_res = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            mode_q     <= 1'b0;
            result_q   <= '0;
            flags      <= '0;
            digit_buf  <= '0;
            active_cnt <= CNT_W'(HEX_D);
        end else begin
            if (state == ST_IDLE && load) begin
                a_q    <= A;
                b_q    <= B;
                op_q   <= opcode_t'(OpCode);
                mode_q <= mode;
            end
            if (state == ST_CALC) begin
                result_q <= alu_res;
                flags    <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
            if (state == ST_UPDATE) begin
                if (mode_q) begin
                    digit_buf  <= BUF_W'(bcd);
                    active_cnt <= CNT_W'(DEC_D);
                end else begin
                    digit_buf  <= BUF_W'(result_q);
                    active_cnt <= CNT_W'(HEX_D);
                end
            end
        end
    end

    bin_to_bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (DEC_D)
    ) u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (state == ST_CONV),
        .bin     (result_q),
        .bcd     (bcd),
        .done    (conv_done)
    );

    // Outputs reload only at the first cycle of a slot, so a buffer write
    // mid-slot shows up at the next slot boundary without disturbing the scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            Anodes   <= '1;
            Segments <= 7'h7f;
        end else begin
            if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
                ref_cnt  <= '0;
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
            if (ref_cnt == '0) begin
                if (CNT_W'(scan_idx) < active_cnt) begin
                    Anodes   <= ~(DIGITS'(1) << scan_idx);
                    Segments <= seg7_hex(digit_buf[{scan_idx, 2'b00} +: 4]);
                end else begin
                    Anodes   <= '1;
                    Segments <= 7'h7f;
                end
            end
        end
    end

endmodule
